// File: rtl/sc_corr_scheduler.sv
// Round-robin scheduler sharing one count-then-regenerate SC correlator among N lanes.
// Capture of the current owner overlaps replay of the previous owner, one window each.
module sc_corr_scheduler #(
  parameter int unsigned W = 5,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] in_bits,
  output logic [N-1:0] grant,
  output logic         corr_in,
  input  logic         corr_out,
  output logic         out_bit,
  output logic [N-1:0] out_valid,
  output logic [N-1:0] done,
  output logic         busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PtrRst = PW'(N - 1);

  logic [W-1:0]  phase;
  logic [PW-1:0] ptr;
  logic          boundary;
  logic          found;
  logic [PW-1:0] winner;
  logic [N-1:0]  winner_oh;
  int unsigned   idx;

  // Phase never stalls so it stays in lockstep with the correlator's own window counter.
  assign boundary = (phase == {W{1'b1}});

  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    winner_oh = found ? (N'(1) << winner) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      ptr       <= PtrRst;
      grant     <= '0;
      out_valid <= '0;
    end else begin
      phase <= phase + W'(1);
      if (boundary) begin
        out_valid <= grant;
        grant     <= winner_oh;
        if (found) begin
          ptr <= winner;
        end
      end
    end
  end

  // grant is one-hot or zero, so AND-OR is the owner mux and yields 0 when idle.
  assign corr_in = |(in_bits & grant);
  assign out_bit = corr_out & (|out_valid);
  assign done    = out_valid & {N{boundary}};
  assign busy    = (|grant) | (|out_valid);

endmodule

// File: tb/tb_sc_corr_scheduler.sv
// Directed bench for sc_corr_scheduler with a behavioural correlator model
// and an expected-value queue popped at each comparison.
module tb_sc_corr_scheduler;

  localparam int unsigned W = 5;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] in_bits;
  logic [N-1:0] grant;
  logic         corr_in;
  logic         corr_out;
  logic         out_bit;
  logic [N-1:0] out_valid;
  logic [N-1:0] done;
  logic         busy;

  logic [W-1:0] tph;
  logic [W:0]   cnt;
  logic [W:0]   latched;
  logic         force_one;

  logic [31:0]  exp_q[$];
  int           n_cmp;
  int           n_bad;
  int           ci;
  int           ob;
  logic [N-1:0] v;
  logic [N-1:0] rr[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  sc_corr_scheduler #(.W(W), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .in_bits(in_bits),
    .grant(grant),
    .corr_in(corr_in),
    .corr_out(corr_out),
    .out_bit(out_bit),
    .out_valid(out_valid),
    .done(done),
    .busy(busy)
  );

  // Stand-in correlator: count ones over a window, then emit that many ones next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tph     <= '0;
      cnt     <= '0;
      latched <= '0;
    end else begin
      tph <= tph + W'(1);
      if (tph == {W{1'b1}}) begin
        latched <= cnt + (W+1)'(corr_in);
        cnt     <= '0;
      end else begin
        cnt <= cnt + (W+1)'(corr_in);
      end
    end
  end

  assign corr_out = force_one | ({1'b0, tph} < latched);

  task automatic push(input logic [31:0] val);
    exp_q.push_back(val);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic goto_phase(input int p);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (int'(tph) != p && k < 64);
    if (int'(tph) != p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto_phase: phase %0d expected %0d", tph, p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req = '0;
    in_bits = '1;
    force_one = 1'b0;
    repeat (2) @(negedge clk);

    push(32'h0); cmp("rst_grant", 32'(grant));
    push(32'h0); cmp("rst_out_valid", 32'(out_valid));
    push(32'h0); cmp("rst_done", 32'(done));
    push(32'h0); cmp("rst_corr_in", 32'(corr_in));
    push(32'h0); cmp("rst_out_bit", 32'(out_bit));
    push(32'h0); cmp("rst_busy", 32'(busy));

    // Single requester held from reset.
    req = 4'b0001;
    in_bits = '0;
    rst = 1'b0;
    goto_phase(31);
    push(32'h0); cmp("w0_grant", 32'(grant));
    goto_phase(0);
    push(32'h1); cmp("w1_grant", 32'(grant));
    push(32'h0); cmp("w1_out_valid", 32'(out_valid));
    push(32'h1); cmp("w1_busy", 32'(busy));
    goto_phase(31);
    push(32'h1); cmp("w1_grant_end", 32'(grant));
    push(32'h0); cmp("w1_done", 32'(done));
    goto_phase(0);
    push(32'h1); cmp("w2_regrant", 32'(grant));
    push(32'h1); cmp("w2_out_valid", 32'(out_valid));
    goto_phase(30);
    push(32'h0); cmp("w2_done_early", 32'(done));
    goto_phase(31);
    push(32'h1); cmp("w2_done", 32'(done));
    req = 4'b0000;
    goto_phase(15);
    push(32'h0); cmp("w3_grant", 32'(grant));
    push(32'h1); cmp("w3_out_valid", 32'(out_valid));
    push(32'h1); cmp("w3_busy", 32'(busy));
    goto_phase(31);
    push(32'h1); cmp("w3_done", 32'(done));

    // Idle window with a forced correlator output; late request for 0101.
    force_one = 1'b1;
    in_bits = '1;
    ob = 0;
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      if (out_bit) ob++;
      if (p == 5) begin
        push(32'h0); cmp("idle_grant", 32'(grant));
        push(32'h0); cmp("idle_out_valid", 32'(out_valid));
        push(32'h0); cmp("idle_busy", 32'(busy));
        push(32'h0); cmp("idle_corr_in", 32'(corr_in));
      end
      if (p == 10) req = 4'b0101;
      if (p == 12) begin
        push(32'h0); cmp("late_req_no_grant", 32'(grant));
      end
    end
    push(32'h0); cmp("idle_out_bit_ones", 32'(ob));
    force_one = 1'b0;

    // Capture for requester 2: 12 ones on lane 2, noise elsewhere.
    ci = 0;
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      if (p == 0) begin
        push(32'h4); cmp("late_grant_ptr_kept", 32'(grant));
      end
      v = 4'($urandom);
      v[2] = (p % 2 == 1) && (p < 24);
      in_bits = v;
      #1;
      if (corr_in) ci++;
      if (p == 10) req = 4'b1000;
      if (p == 12) begin
        push(32'h4); cmp("mid_window_req_ignored", 32'(grant));
      end
    end
    push(32'd12); cmp("capture_ones", 32'(ci));

    // Replay for requester 2 while requester 3 captures.
    ob = 0;
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      in_bits = 4'($urandom);
      if (out_bit) ob++;
      if (p == 0) begin
        push(32'h8); cmp("w6_grant", 32'(grant));
        push(32'h4); cmp("w6_out_valid", 32'(out_valid));
      end
      if (p == 30) begin
        push(32'h0); cmp("w6_done_early", 32'(done));
      end
      if (p == 31) begin
        push(32'h4); cmp("w6_done", 32'(done));
      end
    end
    push(32'd12); cmp("replay_ones", 32'(ob));

    // Reset in the middle of replay.
    goto_phase(20);
    push(32'h8); cmp("w7_out_valid", 32'(out_valid));
    req = 4'b1111;
    in_bits = '1;
    rst = 1'b1;
    #1;
    push(32'h0); cmp("mrst_grant", 32'(grant));
    push(32'h0); cmp("mrst_out_valid", 32'(out_valid));
    push(32'h0); cmp("mrst_done", 32'(done));
    push(32'h0); cmp("mrst_busy", 32'(busy));
    push(32'h0); cmp("mrst_out_bit", 32'(out_bit));
    push(32'h0); cmp("mrst_corr_in", 32'(corr_in));
    @(negedge clk);
    rst = 1'b0;
    goto_phase(31);
    push(32'h0); cmp("post_rst_done", 32'(done));
    push(32'h0); cmp("post_rst_grant", 32'(grant));

    // Round-robin under full demand.
    for (int w = 0; w < 5; w++) begin
      goto_phase(15);
      push(32'(rr[w])); cmp("rr_grant", 32'(grant));
      if (w > 0) begin
        push(32'(rr[w-1])); cmp("rr_out_valid", 32'(out_valid));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_corr_scheduler.md
# sc_corr_scheduler

Round-robin scheduler that time-shares one stochastic-computing correlator (count-then-regenerate, window 2^W bits) among N requesters. Grants the correlator one window at a time, muxes the owner's bitstream into it during a capture window, then routes the regenerated bitstream back to the same requester during the following replay window. Capture of job k+1 overlaps replay of job k. Sits between the SC arithmetic lanes and the shared correlator instance.

## Interface
- W, 5, window exponent; window length L = 2^W cycles; must equal the correlator's width
- N, 4, number of requesters (2..16)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; must be the same reset net as the shared correlator
- req  in  N  per-requester job request, level; sampled only at window boundaries
- in_bits  in  N  per-requester input bitstream
- grant  out  N  one-hot capture owner for current window, all-zero when idle
- corr_in  out  1  bit driven to the correlator input
- corr_out  in  1  regenerated bit from the correlator
- out_bit  out  1  corr_out gated by replay ownership, 0 when no replay
- out_valid  out  N  one-hot replay owner for current window
- done  out  N  one-cycle pulse on the last replay cycle of a job
- busy  out  1  grant or out_valid non-zero

## Operation
- phase: W-bit counter, reset 0, increments every cycle, wraps L-1 -> 0. It stays in lockstep with the correlator's internal window counter because both leave reset on the same edge; the block never stalls phase.
- Window boundary: the clock edge at which phase == L-1. All ownership registers update only on that edge.
- Arbitration at boundary: the winner is the first i with req[i]=1, searched from ptr+1 upward modulo N. grant <= onehot(winner); ptr <= winner. If req is all-zero, grant <= 0 and ptr is unchanged.
- ptr reset value N-1, so requester 0 has first priority.
- Pipeline at the same boundary: out_valid <= grant (old value). The capture owner of window k becomes the replay owner of window k+1.
- corr_in = in_bits[idx(grant)] when grant != 0, else 0. This is combinational.
- out_bit = corr_out when out_valid != 0, else 0. This is combinational.
- done[i] = out_valid[i] && phase == L-1.
- A requester may be capture owner and replay owner in the same window. This happens when it wins back-to-back; round-robin allows it only when no other req is high.
- req is not a handshake. A requester wanting exactly one job drops req once it sees its grant bit. If req is still high at the next boundary, it re-enters arbitration normally.
- The correlator's first window after reset produces no valid count. This needs no special case, because out_valid is 0 until a capture has completed.
- Widths: phase is W bits with modulo-2^W wrap; ptr is ceil(log2 N) bits with modulo-N wrap.

## Timing
- Reset values: phase=0, ptr=N-1, grant=0, out_valid=0, done=0, corr_in=0, out_bit=0, busy=0.
- The first grant can appear at phase 0 of the second window: reset exit, then L cycles, then the boundary edge.
- Job latency: the bit stream is captured during L cycles with grant[i]=1. The replay follows during the next L cycles with out_valid[i]=1. done[i] pulses in the 2L-th cycle after grant[i] rose.
- A req change in mid-window has no effect until the next boundary. Dropping req in mid-window does not abort a capture that is in progress.
- Reset in mid-operation aborts both the capture job and the replay job. No done pulse is issued, and all outputs return to reset values in the same cycle. Arbitration restarts from requester 0.
- Throughput: one job per L cycles when there is continuous demand.

## Test plan
- Single request, W=5, N=4: hold req=0001 from reset. Required: grant=0001 over phases 0..31 of window 1, out_valid=0001 in window 2, done[0] at its phase 31. If req is held, the requester is regranted every window.
- Round-robin: hold req=1111. Required: the grant sequence is 0001, 0010, 0100, 1000, 0001. out_valid lags grant by exactly one window.
- Regeneration: requester 2 feeds 12 ones in 32 bits. Required: exactly 12 ones on out_bit while out_valid=0100, and zero ones on out_bit outside replay.
- Late request: assert req[3] at phase 10. Required: no grant until the next boundary, then grant=1000 at phase 0.
- Mid-job reset: pulse rst during replay at phase 20. Required: all outputs 0 immediately, no done pulse. With req=1111 afterwards, the first grant is 0001.
- Idle gap: req=0000 for one window, then 0100. Required: grant=0000 and busy=0 in the idle window, corr_in=0, ptr unchanged, next grant 0100.
